// File: rtl/im_boot_loader.sv
// im_boot_loader: serial boot loader for the TinyComp core.
// Receives a framed image (sync, 16-bit word count, little-endian words,
// 8-bit additive checksum) from the rs232 RX stream, writes it into
// instruction memory from address 0, and holds the CPU in reset until a
// frame with a matching checksum has been loaded. While the CPU is held
// the loader owns the IM write port and the RX read strobe; otherwise
// both pass straight through from the CPU.
`timescale 1ns/1ps

module im_boot_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_WORDS = 1024,
    parameter bit          BOOT_HOLD = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        charReady,
    input  logic [7:0]  RXchar,
    output logic        RxRead,
    input  logic        CpuReadRX,
    input  logic        CpuWe,
    input  logic [9:0]  CpuAddr,
    input  logic [31:0] CpuDin,
    output logic        ImWe,
    output logic [9:0]  ImAddr,
    output logic [31:0] ImDin,
    output logic        CpuReset,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CSUM,
        RUN
    } state_t;

    localparam state_t      RESET_STATE = BOOT_HOLD ? IDLE : RUN;
    localparam logic [15:0] MAX_LEN     = 16'(MAX_WORDS);

    state_t      state;
    state_t      state_next;

    logic        hold;
    logic        receiving;
    logic        ld_rd;       // loader read strobe, also the byte-capture enable
    logic        rd_guard;    // a read was issued last cycle; charReady is stale

    logic [15:0] len;
    logic [15:0] new_len;
    logic        len_bad;
    logic [10:0] idx;
    logic [10:0] idx_inc;
    logic        last_word;
    logic [1:0]  byte_cnt;
    logic [31:0] word;
    logic [7:0]  csum;
    logic        csum_ok;

    logic        done_q;
    logic        error_q;
    logic        cpu_reset_q;

    assign hold      = (state != RUN);
    assign receiving = (state == IDLE) || (state == LEN_LO) || (state == LEN_HI) ||
                       (state == DATA) || (state == CSUM);
    assign ld_rd     = receiving && charReady && !rd_guard;

    assign new_len   = {RXchar, len[7:0]};
    assign len_bad   = (new_len == 16'd0) || (new_len > MAX_LEN);
    assign idx_inc   = idx + 11'd1;
    assign last_word = ({5'd0, idx_inc} == len);
    assign csum_ok   = (RXchar == csum);

    assign CpuReset  = cpu_reset_q;
    assign Done      = done_q;
    assign Error     = error_q;

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!Reset_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: framing, length validation and checksum decision.
    always_comb begin
        // NOTE: default first so every path assigns state_next; a missing
        // branch would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (ld_rd && (RXchar == SYNC_BYTE)) state_next = LEN_LO;
            LEN_LO:  if (ld_rd) state_next = LEN_HI;
            LEN_HI:  if (ld_rd) state_next = len_bad ? IDLE : DATA;
            DATA:    if (ld_rd && (byte_cnt == 2'd3)) state_next = WRITE;
            WRITE:   state_next = last_word ? CSUM : DATA;
            CSUM:    if (ld_rd) state_next = csum_ok ? RUN : IDLE;
            RUN:     if (Start) state_next = IDLE;
            default: state_next = RESET_STATE;
        endcase
    end

    // Loader datapath: length, word assembly, index, checksum and status flags.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_guard    <= 1'b0;
            len         <= 16'd0;
            idx         <= 11'd0;
            byte_cnt    <= 2'd0;
            word        <= 32'd0;
            csum        <= 8'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= BOOT_HOLD;
        end else begin
            rd_guard    <= RxRead;
            cpu_reset_q <= (state_next != RUN);
            error_q     <= ld_rd && (((state == LEN_HI) && len_bad) ||
                                     ((state == CSUM) && !csum_ok));
            case (state)
                LEN_LO: begin
                    if (ld_rd) len[7:0] <= RXchar;
                end
                LEN_HI: begin
                    if (ld_rd) begin
                        len[15:8] <= RXchar;
                        idx       <= 11'd0;
                        csum      <= 8'd0;
                        byte_cnt  <= 2'd0;
                    end
                end
                DATA: begin
                    if (ld_rd) begin
                        word     <= {RXchar, word[31:8]};
                        csum     <= csum + RXchar;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    idx <= idx_inc;
                end
                CSUM: begin
                    if (ld_rd) done_q <= csum_ok;
                end
                RUN: begin
                    if (Start) done_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Shared-port arbitration: loader owns IM write and RX strobe while holding.
    always_comb begin
        RxRead = CpuReadRX;
        ImWe   = CpuWe;
        ImAddr = CpuAddr;
        ImDin  = CpuDin;
        if (hold) begin
            RxRead = ld_rd;
            ImWe   = (state == WRITE);
            ImAddr = idx[9:0];
            ImDin  = word;
        end
    end

endmodule

// File: tb/tb_im_boot_loader.sv
// tb_im_boot_loader: self-checking bench for im_boot_loader.
// Byte streams are fed through a charReady/RxRead handshake; a negedge
// monitor logs every RX read, IM write and Error cycle. Expected writes,
// error count and final status come from a sequential frame parser.
`timescale 1ns/1ps

module tb_im_boot_loader;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         MAXW = 1024;

    logic        Clock     = 1'b0;
    logic        Reset_n   = 1'b0;
    logic        Start     = 1'b0;
    logic        charReady = 1'b0;
    logic [7:0]  RXchar    = 8'h00;
    logic        RxRead;
    logic        CpuReadRX = 1'b0;
    logic        CpuWe     = 1'b0;
    logic [9:0]  CpuAddr   = 10'd0;
    logic [31:0] CpuDin    = 32'd0;
    logic        ImWe;
    logic [9:0]  ImAddr;
    logic [31:0] ImDin;
    logic        CpuReset;
    logic        Done;
    logic        Error;

    im_boot_loader dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .charReady (charReady),
        .RXchar    (RXchar),
        .RxRead    (RxRead),
        .CpuReadRX (CpuReadRX),
        .CpuWe     (CpuWe),
        .CpuAddr   (CpuAddr),
        .CpuDin    (CpuDin),
        .ImWe      (ImWe),
        .ImAddr    (ImAddr),
        .ImDin     (ImDin),
        .CpuReset  (CpuReset),
        .Done      (Done),
        .Error     (Error)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          cyc;
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit          run;
        logic        cpu_we;
        logic [9:0]  cpu_addr;
        logic [31:0] cpu_din;
        logic        cpu_rd;
        logic        exp_we;
        logic [9:0]  exp_addr;
        logic [31:0] exp_din;
        logic        exp_rd;
        bit          chk_bus;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         err_cnt  = 0;
    wr_t        wr_log[$];
    int         rd_log[$];
    logic [7:0] stim_q[$];
    wr_t        exp_wr[$];
    int         exp_err;
    bit         exp_done;
    vec_t       vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Negedge monitor of reads, writes and error cycles.
    initial begin
        wr_t w;
        forever begin
            @(negedge Clock);
            cyc++;
            if (Reset_n) begin
                if (RxRead) rd_log.push_back(cyc);
                if (ImWe) begin
                    w.cyc  = cyc;
                    w.addr = ImAddr;
                    w.data = ImDin;
                    wr_log.push_back(w);
                end
                if (Error) err_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        err_cnt = 0;
    endtask

    // Wait (bounded) for the loader to take the byte on RXchar, then drop charReady.
    task automatic wait_read(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clock);
            if (RxRead) got = 1'b1;
            tick();
        end
        charReady = 1'b0;
        check(name, got, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        charReady = 1'b1;
        RXchar    = b;
        wait_read("byte_taken");
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Reference parser: walks the byte stream as a software loader would.
    task automatic model_stream();
        int   i;
        int   n;
        int   len;
        int   sum;
        wr_t  w;
        exp_wr.delete();
        exp_err  = 0;
        exp_done = 1'b0;
        n = stim_q.size();
        i = 0;
        while (i < n && !exp_done) begin
            if (stim_q[i] != SYNC) begin
                i++;
                continue;
            end
            if (i + 2 >= n) break;
            len = int'(stim_q[i+1]) + 256 * int'(stim_q[i+2]);
            i += 3;
            if (len == 0 || len > MAXW) begin
                exp_err++;
                continue;
            end
            sum = 0;
            for (int k = 0; k < len; k++) begin
                w.cyc  = 0;
                w.addr = 10'(k);
                w.data = {stim_q[i+4*k+3], stim_q[i+4*k+2], stim_q[i+4*k+1], stim_q[i+4*k]};
                for (int j = 0; j < 4; j++) sum = (sum + int'(stim_q[i+4*k+j])) % 256;
                exp_wr.push_back(w);
            end
            i += 4 * len;
            if (int'(stim_q[i]) == sum) exp_done = 1'b1;
            else exp_err++;
            i++;
        end
    endtask

    // Feed stim_q to the DUT and compare everything observed with the parser.
    task automatic run_stream(input string tag);
        int nbad;
        clear_logs();
        foreach (stim_q[k]) send_byte(stim_q[k]);
        repeat (3) tick();
        model_stream();
        check({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
        nbad = 0;
        for (int k = 0; k < wr_log.size() && k < exp_wr.size(); k++) begin
            if (wr_log[k].addr !== exp_wr[k].addr || wr_log[k].data !== exp_wr[k].data) nbad++;
        end
        check({tag, "_wr_bad"}, nbad, 0);
        check({tag, "_errors"}, err_cnt, exp_err);
        check({tag, "_done"}, Done, exp_done);
        check({tag, "_cpureset"}, CpuReset, !exp_done);
    endtask

    task automatic push_frame(input int len, input bit good);
        int         s;
        logic [7:0] b;
        logic [15:0] l16;
        l16 = 16'(len);
        stim_q.push_back(SYNC);
        stim_q.push_back(l16[7:0]);
        stim_q.push_back(l16[15:8]);
        s = 0;
        for (int k = 0; k < 4 * len; k++) begin
            b = 8'($urandom);
            s = (s + int'(b)) % 256;
            stim_q.push_back(b);
        end
        if (!good) s = (s + 1 + int'($urandom_range(0, 254))) % 256;
        stim_q.push_back(8'(s));
    endtask

    task automatic gen_random_stream();
        logic [7:0] b;
        int         nbad;
        stim_q.delete();
        repeat ($urandom_range(0, 3)) begin
            b = 8'($urandom);
            while (b == SYNC) b = 8'($urandom);
            stim_q.push_back(b);
        end
        nbad = int'($urandom_range(0, 2));
        for (int k = 0; k < nbad; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                stim_q.push_back(SYNC);
                if ($urandom_range(0, 1) == 1) begin
                    stim_q.push_back(8'h00);
                    stim_q.push_back(8'h00);
                end else begin
                    stim_q.push_back(8'($urandom));
                    stim_q.push_back(8'($urandom_range(5, 255)));
                end
            end else begin
                push_frame(int'($urandom_range(1, 4)), 1'b0);
            end
        end
        push_frame(int'($urandom_range(1, 6)), 1'b1);
    endtask

    task automatic apply_vecs(input bit in_run);
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].run == in_run) begin
                CpuWe     = vecs[i].cpu_we;
                CpuAddr   = vecs[i].cpu_addr;
                CpuDin    = vecs[i].cpu_din;
                CpuReadRX = vecs[i].cpu_rd;
                @(negedge Clock);
                check($sformatf("vec%0d_imwe", i), ImWe, vecs[i].exp_we);
                check($sformatf("vec%0d_rxread", i), RxRead, vecs[i].exp_rd);
                if (vecs[i].chk_bus) begin
                    check($sformatf("vec%0d_imaddr", i), ImAddr, vecs[i].exp_addr);
                    check($sformatf("vec%0d_imdin", i), ImDin, vecs[i].exp_din);
                end
                tick();
            end
        end
        CpuWe     = 1'b0;
        CpuAddr   = 10'd0;
        CpuDin    = 32'd0;
        CpuReadRX = 1'b0;
    endtask

    initial begin
        bit got;

        vecs[0] = '{1'b1, 1'b1, 10'h3FF, 32'hCAFEF00D, 1'b0, 1'b1, 10'h3FF, 32'hCAFEF00D, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 10'h155, 32'h12345678, 1'b1, 1'b0, 10'h155, 32'h12345678, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 10'h000, 32'hFFFFFFFF, 1'b1, 1'b1, 10'h000, 32'hFFFFFFFF, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 10'h2AA, 32'h00000000, 1'b0, 1'b0, 10'h2AA, 32'h00000000, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 10'h3FF, 32'hCAFEF00D, 1'b0, 1'b0, 10'h000, 32'h00000000, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 10'h000, 32'h5A5A5A5A, 1'b1, 1'b0, 10'h000, 32'h00000000, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(negedge Clock);
        check("rst_cpureset", CpuReset, 1'b1);
        check("rst_done", Done, 1'b0);
        check("rst_error", Error, 1'b0);
        check("rst_rxread", RxRead, 1'b0);
        check("rst_imwe", ImWe, 1'b0);
        tick();
        Reset_n = 1'b1;
        @(negedge Clock);
        check("post_rst_cpureset", CpuReset, 1'b1);
        check("post_rst_done", Done, 1'b0);
        tick();

        // Non-sync bytes in IDLE are read and discarded.
        stim_q = '{8'h00, 8'h5A};
        run_stream("idle_junk");
        check("idle_junk_reads", rd_log.size(), 2);

        // Two-word frame; each write lands one cycle after its 4th byte read.
        stim_q = '{8'hA5, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hE2};
        run_stream("frame2");
        if (wr_log.size() == 2 && rd_log.size() == 12) begin
            check("frame2_w0_data", wr_log[0].data, 32'h11223344);
            check("frame2_w1_data", wr_log[1].data, 32'hDEADBEEF);
            check("frame2_w0_timing", wr_log[0].cyc, rd_log[6] + 1);
            check("frame2_w1_timing", wr_log[1].cyc, rd_log[10] + 1);
        end else begin
            check("frame2_log_shape", wr_log.size() * 100 + rd_log.size(), 212);
        end

        // CPU owns the shared ports in RUN.
        apply_vecs(1'b1);

        // Start in RUN: CpuReset and Done change on the next edge only.
        Start = 1'b1;
        @(negedge Clock);
        check("start_pre_cpureset", CpuReset, 1'b0);
        check("start_pre_done", Done, 1'b1);
        tick();
        Start = 1'b0;
        @(negedge Clock);
        check("start_post_cpureset", CpuReset, 1'b1);
        check("start_post_done", Done, 1'b0);
        tick();

        // CPU inputs ignored while held.
        apply_vecs(1'b0);

        // Bad checksum, then a good frame.
        stim_q = '{8'hA5, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hE3};
        run_stream("bad_csum");
        stim_q = '{8'hA5, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hE2};
        run_stream("retry_ok");
        pulse_start();

        // Length 1025 and length 0 both rejected without IM writes.
        stim_q = '{8'hA5, 8'h01, 8'h04, 8'hA5, 8'h00, 8'h00};
        run_stream("bad_len");

        // charReady together with Start in RUN: loader does not take that byte.
        stim_q.delete();
        push_frame(2, 1'b1);
        run_stream("pre_simul");
        Start     = 1'b1;
        charReady = 1'b1;
        RXchar    = 8'h00;
        @(negedge Clock);
        check("simul_no_read", RxRead, 1'b0);
        tick();
        Start = 1'b0;
        wait_read("simul_later_read");
        check("simul_cpureset", CpuReset, 1'b1);

        // Reset mid-load after two of four words.
        stim_q.delete();
        push_frame(4, 1'b1);
        clear_logs();
        for (int k = 0; k < 11; k++) send_byte(stim_q[k]);
        repeat (2) tick();
        check("midload_writes", wr_log.size(), 2);
        Reset_n = 1'b0;
        #1;
        check("midload_rst_cpureset", CpuReset, 1'b1);
        check("midload_rst_done", Done, 1'b0);
        check("midload_rst_imwe", ImWe, 1'b0);
        repeat (2) tick();
        Reset_n = 1'b1;
        tick();
        stim_q.delete();
        push_frame(4, 1'b1);
        run_stream("after_rst");

        // Asynchronous reset in RUN drops Done without a clock edge.
        #2;
        Reset_n = 1'b0;
        #1;
        check("run_rst_done", Done, 1'b0);
        check("run_rst_cpureset", CpuReset, 1'b1);
        tick();
        Reset_n = 1'b1;
        tick();

        // Largest legal image: 1024 words, last address 0x3FF.
        stim_q.delete();
        push_frame(MAXW, 1'b1);
        run_stream("max_len");
        got = (wr_log.size() > 0);
        check("max_len_any_write", got, 1'b1);
        if (got) check("max_len_last_addr", wr_log[wr_log.size()-1].addr, 10'h3FF);
        pulse_start();

        // Randomized frames with junk, bad lengths and bad checksums.
        for (int r = 0; r < 15; r++) begin
            gen_random_stream();
            run_stream($sformatf("rand%0d", r));
            pulse_start();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/im_boot_loader.md
Name: im_boot_loader

Overview:
- Serial boot loader and shared-resource arbiter for the TinyComp core.
- Receives a framed program image from the rs232 RX byte stream and writes it into instruction memory starting at address 0.
- Holds the CPU in reset while it loads; releases the CPU once the image checksum passes.
- Arbitrates two shared ports between loader and CPU: the IM write port (loader vs StoreI) and the RX read strobe (loader vs CPU IO read).

Parameters:
SYNC_BYTE, 8'hA5, frame start byte.
MAX_WORDS, 1024, largest legal image in words (IM depth).
BOOT_HOLD, 1, 1: come out of reset in IDLE with the CPU held; 0: come out of reset in RUN.

Ports:
Clock  input  1  system clock, 50 MHz.
Reset_n  input  1  asynchronous, active-low reset.
Start  input  1  one-cycle request to reload; honoured only in RUN.
charReady  input  1  rs232 has an RX byte.
RXchar  input  8  rs232 RX byte.
RxRead  output  1  read strobe to rs232.
CpuReadRX  input  1  CPU RX read strobe.
CpuWe  input  1  CPU StoreI write enable.
CpuAddr  input  10  CPU IM write address.
CpuDin  input  32  CPU IM write data.
ImWe  output  1  IM write enable.
ImAddr  output  10  IM write address.
ImDin  output  32  IM write data.
CpuReset  output  1  high-true reset to the CPU PC.
Done  output  1  last load succeeded. Stays high in RUN; clears on Start.
Error  output  1  one-cycle pulse on a bad length or checksum.

Behaviour:
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, RUN.
- Reset (async, Reset_n=0):
  - State = IDLE if BOOT_HOLD=1, else RUN.
  - CpuReset=1 (IDLE) or 0 (RUN). Done=0, Error=0, RxRead=0, ImWe=0.
  - Counters, byte shift register and checksum cleared.
  - Reset asserted mid-load abandons the frame. IM keeps whatever words were already written.
- Hold = (state != RUN). CpuReset = Hold, registered, changing on the state-transition edge.
- Arbitration (combinational):
  - When Hold: RxRead = loader strobe; ImWe/ImAddr/ImDin = loader values. CpuWe and CpuReadRX are ignored.
  - When not Hold: RxRead = CpuReadRX; Im* = Cpu*.
- Byte acceptance (all receiving states, Hold only):
  - If charReady=1 and no read was issued in the previous cycle, assert the loader strobe for exactly one cycle and capture RXchar in that cycle.
  - The cycle after a read is a guard cycle: charReady is ignored.
- IDLE: accept bytes. SYNC_BYTE -> LEN_LO. Any other byte is discarded; stay in IDLE.
- LEN_LO: accepted byte -> len[7:0]; go to LEN_HI.
- LEN_HI: accepted byte -> len[15:8].
  - If len==0 or len>MAX_WORDS: Error pulse, go to IDLE.
  - Otherwise clear word index and checksum, go to DATA.
- DATA:
  - Bytes arrive little-endian and shift into word bits [31:24] downward, so byte0 -> [7:0] and byte3 -> [31:24].
  - checksum += byte, mod 256.
  - On the 4th byte go to WRITE.
- WRITE (one cycle):
  - ImWe=1, ImAddr=word index[9:0], ImDin=assembled word.
  - Write occurs one cycle after the 4th byte strobe.
  - Increment index. Go to CSUM if index+1==len, else DATA.
- CSUM: accept one byte.
  - Equal to checksum: Done=1, go to RUN. CpuReset falls on the same edge; CPU starts at PC=0.
  - Not equal: Error pulse, Done=0, go to IDLE (CPU stays held).
- RUN: Start=1 -> IDLE, Done=0, CpuReset=1 next edge. Start in any other state is ignored.
- Simultaneous charReady and Start in RUN: the byte is left to the CPU; the loader's first read happens no earlier than the cycle after entering IDLE.
- Index wrap: len ≤ 1024 guarantees index ≤ 1023. Index width is 11 bits internally; ImAddr uses bits [9:0].

Test Plan:
1. Reset_n=0 then 1, BOOT_HOLD=1 -> CpuReset=1, Done=0. Bytes 00 then 5A -> RxRead pulses twice, state stays IDLE, ImWe never asserted.
2. Bytes A5 02 00 44 33 22 11 EF BE AD DE E2 -> ImWe at addr 0 with 0x11223344 and at addr 1 with 0xDEADBEEF, each one cycle after its 4th byte. Then Done=1 and CpuReset=0.
3. Same frame with checksum E3 -> one Error pulse, Done=0, CpuReset stays 1, state returns to IDLE. A correct frame sent next succeeds.
4. Bytes A5 01 04 (len=1025) -> Error pulse, no IM writes. Bytes A5 00 00 -> Error pulse.
5. In RUN, CpuWe=1, CpuAddr=0x3FF, CpuDin=0xCAFEF00D -> ImWe/ImAddr/ImDin pass through the same cycle. CpuReadRX passes to RxRead. In IDLE, the same CPU inputs give ImWe=0.
6. Pull Reset_n low after 2 DATA words of a 4-word frame -> CpuReset=1, Done=0 immediately. After release, a full valid frame loads correctly. Start pulse in RUN -> CpuReset=1 and Done=0 on the next edge.
